// File: rtl/floo_rob_id_tracker.sv
// rtl/floo_rob_id_tracker.sv - per-ID outstanding tracker deciding RoB tagging ahead of the reorder buffer
module floo_rob_id_tracker #(
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter type         dest_t       = logic,
  parameter type         id_t         = logic [IdWidth-1:0]
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  ax_valid_i,
  output logic  ax_ready_o,
  input  id_t   ax_id_i,
  input  dest_t ax_dest_i,
  output logic  ax_valid_o,
  input  logic  ax_ready_i,
  output logic  ax_rob_req_o,
  input  logic  rsp_valid_i,
  input  logic  rsp_ready_i,
  input  id_t   rsp_id_i,
  input  logic  rsp_last_i,
  output logic  idle_o
);

  localparam int unsigned NumIds   = 2 ** IdWidth;
  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);
  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t MaxCnt = cnt_t'(MaxTxnsPerId);

  cnt_t  cnt_q  [NumIds];
  cnt_t  cnt_d  [NumIds];
  dest_t dest_q [NumIds];
  dest_t dest_d [NumIds];
  logic  ro_q   [NumIds];
  logic  ro_d   [NumIds];

  logic              full;
  logic              accept;
  logic              retire;
  logic              rsp_cnt_zero;
  logic [NumIds-1:0] acc_hit;
  logic [NumIds-1:0] ret_hit;

  // Full uses the pre-retire count, so a same-cycle retire only unblocks next cycle.
  assign full         = (cnt_q[ax_id_i] == MaxCnt);
  assign ax_valid_o   = ax_valid_i && !full;
  assign ax_ready_o   = ax_ready_i && !full;
  assign ax_rob_req_o = (cnt_q[ax_id_i] != '0) &&
                        ((ax_dest_i != dest_q[ax_id_i]) || ro_q[ax_id_i]);
  assign accept       = ax_valid_o && ax_ready_i;
  assign retire       = rsp_valid_i && rsp_ready_i && rsp_last_i;
  assign rsp_cnt_zero = (cnt_q[rsp_id_i] == '0);

  always_comb begin
    acc_hit = '0;
    ret_hit = '0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      acc_hit[i] = accept && (ax_id_i == id_t'(i));
      ret_hit[i] = retire && (rsp_id_i == id_t'(i));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NumIds; i++) begin
      cnt_d[i]  = cnt_q[i];
      dest_d[i] = dest_q[i];
      ro_d[i]   = ro_q[i];
      if (acc_hit[i]) begin
        dest_d[i] = ax_dest_i;
        ro_d[i]   = ro_q[i] | ax_rob_req_o;
        if (!ret_hit[i]) cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end else if (ret_hit[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
        if (cnt_q[i] == cnt_t'(1)) ro_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        cnt_q[i]  <= '0;
        dest_q[i] <= '0;
        ro_q[i]   <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        cnt_q[i]  <= cnt_d[i];
        dest_q[i] <= dest_d[i];
        ro_q[i]   <= ro_d[i];
      end
    end
  end

  always_comb begin
    idle_o = 1'b1;
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (cnt_q[i] != '0) idle_o = 1'b0;
    end
  end

  a_valid_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ax_valid_i && !ax_ready_o) |=> ax_valid_i);
  a_no_retire_on_zero : assert property (@(posedge clk_i) disable iff (!rst_ni)
    retire |-> !rsp_cnt_zero);
  a_max_txns : assert property (@(posedge clk_i) MaxTxnsPerId >= 1);

endmodule

// File: tb/tb_floo_rob_id_tracker.sv
// tb/tb_floo_rob_id_tracker.sv - vector and scoreboard bench for floo_rob_id_tracker
module tb_floo_rob_id_tracker;

  logic       clk;
  logic       rst_n;
  logic       ax_valid_i;
  logic       ax_ready_o;
  logic [3:0] ax_id_i;
  logic [2:0] ax_dest_i;
  logic       ax_valid_o;
  logic       ax_ready_i;
  logic       ax_rob_req_o;
  logic       rsp_valid_i;
  logic       rsp_ready_i;
  logic [3:0] rsp_id_i;
  logic       rsp_last_i;
  logic       idle_o;

  floo_rob_id_tracker #(
    .IdWidth     (4),
    .MaxTxnsPerId(4),
    .dest_t      (logic [2:0])
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ax_valid_i  (ax_valid_i),
    .ax_ready_o  (ax_ready_o),
    .ax_id_i     (ax_id_i),
    .ax_dest_i   (ax_dest_i),
    .ax_valid_o  (ax_valid_o),
    .ax_ready_i  (ax_ready_i),
    .ax_rob_req_o(ax_rob_req_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_i    (rsp_id_i),
    .rsp_last_i  (rsp_last_i),
    .idle_o      (idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [3:0] aid;
    logic [2:0] ad;
    logic       rv;
    logic       rr;
    logic       rl;
    logic [3:0] rid;
    logic       evo;
    logic       ero;
    logic       erob;
    logic       eidle;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   row   = 0;

  function automatic vec_t mk(input logic av, input logic [3:0] aid, input logic [2:0] ad,
                              input logic rv, input logic rr, input logic rl, input logic [3:0] rid,
                              input logic evo, input logic ero, input logic erob, input logic eidle);
    vec_t v;
    v.av = av; v.aid = aid; v.ad = ad;
    v.rv = rv; v.rr = rr; v.rl = rl; v.rid = rid;
    v.evo = evo; v.ero = ero; v.erob = erob; v.eidle = eidle;
    return v;
  endfunction

  // Accepted request, last-beat retire, and quiet cycle.
  function automatic vec_t req(input logic [3:0] id, input logic [2:0] d, input logic rob, input logic idle);
    return mk(1, id, d, 0, 0, 0, 0, 1, 1, rob, idle);
  endfunction
  function automatic vec_t ret(input logic [3:0] id, input logic idle);
    return mk(0, 0, 0, 1, 1, 1, id, 0, 1, 0, idle);
  endfunction
  function automatic vec_t nop(input logic idle);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, idle);
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%b want=%b", nm, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    ax_valid_i  = v.av;
    ax_id_i     = v.aid;
    ax_dest_i   = v.ad;
    rsp_valid_i = v.rv;
    rsp_ready_i = v.rr;
    rsp_last_i  = v.rl;
    rsp_id_i    = v.rid;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("ax_valid_o", ax_valid_o, e.evo);
    chk("ax_ready_o", ax_ready_o, e.ero);
    chk("ax_rob_req_o", ax_rob_req_o, e.erob);
    chk("idle_o", idle_o, e.eidle);
    row++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    ax_valid_i  = 1'b0;
    ax_id_i     = '0;
    ax_dest_i   = '0;
    ax_ready_i  = 1'b1;
    rsp_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    rsp_id_i    = '0;
    rsp_last_i  = 1'b0;

    vecs.push_back(nop(1));
    // same destination on ID 3, count checked by idle after exactly 3 retires
    vecs.push_back(req(3, 5, 0, 1));
    vecs.push_back(req(3, 5, 0, 0));
    vecs.push_back(req(3, 5, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(ret(3, 0));
    vecs.push_back(nop(1));
    // destination change and sticky reorder flag on ID 2
    vecs.push_back(req(2, 1, 0, 1));
    vecs.push_back(req(2, 4, 1, 0));
    vecs.push_back(req(2, 4, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(ret(2, 0));
    vecs.push_back(req(2, 7, 0, 1));
    vecs.push_back(req(2, 7, 0, 0));
    vecs.push_back(ret(2, 0));
    vecs.push_back(ret(2, 0));
    vecs.push_back(nop(1));
    // saturation on ID 1; same-cycle retire does not unblock
    vecs.push_back(req(1, 0, 0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(req(1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(req(1, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(ret(1, 0));
    vecs.push_back(nop(1));
    // simultaneous accept/retire: same ID keeps count, different IDs both apply
    vecs.push_back(req(6, 2, 0, 1));
    vecs.push_back(mk(1, 6, 3, 1, 1, 1, 6, 1, 1, 1, 0));
    vecs.push_back(ret(6, 0));
    vecs.push_back(nop(1));
    vecs.push_back(req(5, 0, 0, 1));
    vecs.push_back(mk(1, 4, 0, 1, 1, 1, 5, 1, 1, 0, 0));
    vecs.push_back(ret(4, 0));
    vecs.push_back(nop(1));
    // burst on ID 0: only the handshaked last beat retires
    vecs.push_back(req(0, 0, 0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
    vecs.push_back(nop(1));
    // five IDs outstanding before the mid-operation reset
    for (int i = 0; i < 5; i++) vecs.push_back(req(4'(8 + i), 1, 0, (i == 0)));

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) apply(vecs[k]);

    // hand-written: asynchronous reset mid-cycle with requests pending
    ax_valid_i = 1'b1;
    ax_id_i    = 4'd8;
    ax_dest_i  = 3'd5;
    #1;
    chk("pre_reset_rob", ax_rob_req_o, 1'b1);
    chk("pre_reset_idle", idle_o, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_idle", idle_o, 1'b1);
    chk("reset_valid_pass", ax_valid_o, 1'b1);
    chk("reset_rob", ax_rob_req_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_rob", ax_rob_req_o, 1'b0);
    chk("post_reset_valid", ax_valid_o, 1'b1);
    chk("post_reset_idle", idle_o, 1'b1);
    @(posedge clk);
    #1;
    ax_dest_i = 3'd6;
    @(negedge clk);
    chk("post_reset_second_rob", ax_rob_req_o, 1'b1);
    chk("post_reset_second_idle", idle_o, 1'b0);
    @(posedge clk);
    #1;
    ax_valid_i = 1'b0;
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
